// File: rtl/frame_status_leds_if.sv
// frame_status_leds_if: frame/mode/brightness inputs and tick/LED outputs of the status-LED driver.
// Latency: none, plain signal grouping.
// Backpressure: none, frame pulses are fire-and-forget and outputs are always valid.
interface frame_status_leds_if #(
  parameter int NUM_LEDS = 3,
  parameter int PWM_BITS = 4
);
  logic                new_frame;
  logic                hold;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic                tick;
  logic [NUM_LEDS-1:0] leds_out;

  modport master (
    output new_frame, hold, mode, brightness,
    input  tick, leds_out
  );

  modport slave (
    input  new_frame, hold, mode, brightness,
    output tick, leds_out
  );
endinterface

// File: rtl/frame_status_leds.sv
// frame_status_leds: counts frames, steps a 4-mode LED pattern every FRAMES_PER_TICK frames.
// Latency: counted frame -> tick one cycle later -> leds_out shows new pattern one cycle after tick.
// Backpressure: none; frames seen while hold=1 are dropped. Optional PWM dimming under LED_PWM_EN.
module frame_status_leds #(
  parameter int NUM_LEDS        = 3,
  parameter int FRAMES_PER_TICK = 60,
  parameter int PWM_BITS        = 4,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset,
  frame_status_leds_if.slave bus
);
  localparam int                  CW        = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam logic [CW-1:0]       LAST_CNT  = CW'(FRAMES_PER_TICK - 1);
  localparam logic [NUM_LEDS-1:0] ALL_ONES  = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LEDS_DARK = (ACTIVE_LOW != 0) ? ALL_ONES : '0;

  logic [CW-1:0]       r_frame_cnt;
  logic [NUM_LEDS-1:0] r_pattern;
  logic [NUM_LEDS-1:0] r_leds;
  logic [1:0]          r_cur_mode;
  logic                r_tick;

  logic                w_counted;
  logic                w_wrap;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_pattern_nxt;
  logic [NUM_LEDS-1:0] w_lit;

  // hold wins over new_frame: a coincident frame is simply lost
  assign w_counted = bus.new_frame & ~bus.hold;
  assign w_wrap    = w_counted & (r_frame_cnt == LAST_CNT);

  // Frame counter; tick is a one-cycle pulse registered on the wrapping frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap) begin
        r_frame_cnt <= '0;
      end else if (w_counted) begin
        r_frame_cnt <= r_frame_cnt + CW'(1);
      end
    end
  end

  // Next pattern for a tick: load the mode's seed on a mode change, else advance
  always_comb begin
    w_pattern_nxt = r_pattern;
    if (bus.mode != r_cur_mode) begin
      case (bus.mode)
        2'b01:   w_pattern_nxt = NUM_LEDS'(1);
        2'b10:   w_pattern_nxt = ALL_ONES;
        default: w_pattern_nxt = '0;
      endcase
    end else begin
      case (r_cur_mode)
        2'b00:   w_pattern_nxt = r_pattern + NUM_LEDS'(1);
        2'b01:   w_pattern_nxt = (r_pattern << 1) | (r_pattern >> (NUM_LEDS - 1));
        2'b10:   w_pattern_nxt = ~r_pattern;
        default: w_pattern_nxt = '0;
      endcase
    end
  end

  // Pattern and active mode change only on the edge that raises tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern  <= '0;
      r_cur_mode <= 2'b00;
    end else if (w_wrap) begin
      r_pattern  <= w_pattern_nxt;
      r_cur_mode <= bus.mode;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] r_pwm_cnt;

  // Free-running PWM phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Full-scale brightness forces steady on; otherwise duty = brightness / 2^PWM_BITS
  assign w_pwm_on = (&bus.brightness) | (r_pwm_cnt < bus.brightness);
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_lit = r_pattern & {NUM_LEDS{w_pwm_on}};

  // Registered pin drive with LED polarity applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= LEDS_DARK;
    end else begin
      r_leds <= (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
    end
  end

  assign bus.tick     = r_tick;
  assign bus.leds_out = r_leds;
endmodule

// File: tb/tb_frame_status_leds.sv
// tb_frame_status_leds: three driver instances (4 / 60 / 1 frames per tick) against a behavioural model.
// Latency: model and DUTs are compared every cycle on the falling edge.
// Backpressure: none; stimulus is driven on falling edges.
module tb_frame_status_leds;
  localparam int NL   = 3;
  localparam int PB   = 4;
  localparam int FULL = (1 << NL) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus and observed outputs
  logic          nf [3];
  logic          hd [3];
  logic [1:0]    md [3];
  logic [PB-1:0] br [3];
  logic          tick_o [3];
  logic [NL-1:0] leds_o [3];

  frame_status_leds_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) if0 ();
  frame_status_leds_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) if1 ();
  frame_status_leds_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) if2 ();

  assign if0.new_frame = nf[0]; assign if0.hold = hd[0]; assign if0.mode = md[0]; assign if0.brightness = br[0];
  assign if1.new_frame = nf[1]; assign if1.hold = hd[1]; assign if1.mode = md[1]; assign if1.brightness = br[1];
  assign if2.new_frame = nf[2]; assign if2.hold = hd[2]; assign if2.mode = md[2]; assign if2.brightness = br[2];
  assign tick_o[0] = if0.tick; assign leds_o[0] = if0.leds_out;
  assign tick_o[1] = if1.tick; assign leds_o[1] = if1.leds_out;
  assign tick_o[2] = if2.tick; assign leds_o[2] = if2.leds_out;

  frame_status_leds #(.NUM_LEDS(NL), .FRAMES_PER_TICK(4), .PWM_BITS(PB), .ACTIVE_LOW(1))
    u_fpt4 (.clk(clk), .reset(reset), .bus(if0));
  frame_status_leds #(.NUM_LEDS(NL), .FRAMES_PER_TICK(60), .PWM_BITS(PB), .ACTIVE_LOW(1))
    u_fpt60 (.clk(clk), .reset(reset), .bus(if1));
  frame_status_leds #(.NUM_LEDS(NL), .FRAMES_PER_TICK(1), .PWM_BITS(PB), .ACTIVE_LOW(0))
    u_fpt1 (.clk(clk), .reset(reset), .bus(if2));

  // ---------------- behavioural reference model ----------------
  int fpt [3] = '{4, 60, 1};
  int al  [3] = '{1, 1, 0};
  int m_cnt [3], m_pat [3], m_mode [3], m_tick [3], m_leds [3];
  int m_pwm, m_lit, m_pon;

  function automatic int seed(int m);
    case (m)
      1:       return 1;
      2:       return FULL;
      default: return 0;
    endcase
  endfunction

  function automatic int advance(int m, int p);
    case (m)
      0:       return (p + 1) % (FULL + 1);
      1:       return ((p * 2) % (FULL + 1)) + (p >> (NL - 1));
      2:       return FULL - p;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        m_cnt[d] = 0; m_pat[d] = 0; m_mode[d] = 0; m_tick[d] = 0;
        m_leds[d] = (al[d] != 0) ? FULL : 0;
      end
      m_pwm = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_pon = 1;
`ifdef LED_PWM_EN
        m_pon = ((int'(br[d]) == (1 << PB) - 1) || (m_pwm < int'(br[d]))) ? 1 : 0;
`endif
        m_lit = (m_pon != 0) ? m_pat[d] : 0;
        m_leds[d] = (al[d] != 0) ? FULL - m_lit : m_lit;
        m_tick[d] = 0;
        if (nf[d] && !hd[d]) begin
          m_cnt[d] = m_cnt[d] + 1;
          if (m_cnt[d] == fpt[d]) begin
            m_cnt[d]  = 0;
            m_tick[d] = 1;
            if (int'(md[d]) != m_mode[d]) begin
              m_mode[d] = int'(md[d]);
              m_pat[d]  = seed(m_mode[d]);
            end else begin
              m_pat[d] = advance(m_mode[d], m_pat[d]);
            end
          end
        end
      end
      m_pwm = (m_pwm + 1) % (1 << PB);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int tick_seen [3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and compare every instance against the model
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_tick%0d", d), 32'(tick_o[d]), m_tick[d]);
      chk($sformatf("model_leds%0d", d), 32'(leds_o[d]), m_leds[d]);
      tick_seen[d] += int'(tick_o[d]);
    end
  endtask

  typedef struct {
    logic       nf;
    logic       hd;
    logic [1:0] md;
    logic       tk;
    logic [2:0] leds;
  } vec_t;

  vec_t tbl [17];
  int   exp_pat;
  int   base;
  int   lit_cnt;

  initial begin
    for (int d = 0; d < 3; d++) begin
      nf[d] = 1'b0; hd[d] = 1'b0; md[d] = 2'b00; br[d] = '1;
    end

    // Single-step table for the 1-frame-per-tick, active-high instance
    tbl[0]  = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd1};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd2};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 3'd4};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 3'd1};
    tbl[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 3'd1};
    tbl[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 3'd1};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd1};
    tbl[8]  = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd7};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd0};
    tbl[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 3'd7};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'd7};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'd0};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'd1};
    tbl[14] = '{1'b1, 1'b0, 2'd3, 1'b1, 3'd2};
    tbl[15] = '{1'b1, 1'b0, 2'd3, 1'b1, 3'd0};
    tbl[16] = '{1'b0, 1'b0, 2'd3, 1'b0, 3'd0};

    // Reset values
    #1 reset = 1'b1;
    #12;
    chk("rst_tick0", 32'(tick_o[0]), 0);
    chk("rst_leds0", 32'(leds_o[0]), 7);
    chk("rst_leds1", 32'(leds_o[1]), 7);
    chk("rst_leds2", 32'(leds_o[2]), 0);
    @(negedge clk);
    reset = 1'b0;

    // Walk, blink, binary and off modes, hold, back-to-back frames
    for (int i = 0; i < 17; i++) begin
      nf[2] = tbl[i].nf; hd[2] = tbl[i].hd; md[2] = tbl[i].md;
      step();
      chk($sformatf("tbl%0d_tick", i), 32'(tick_o[2]), 32'(tbl[i].tk));
      chk($sformatf("tbl%0d_leds", i), 32'(leds_o[2]), 32'(tbl[i].leds));
    end
    nf[2] = 1'b0; hd[2] = 1'b0;

    // Binary count with 4 frames per tick: 36 frames -> 9 ticks
    md[0] = 2'b00;
    base = tick_seen[0];
    exp_pat = 0;
    for (int f = 0; f < 36; f++) begin
      nf[0] = 1'b1;
      step();
      if (tick_o[0]) exp_pat = (exp_pat + 1) % 8;
      nf[0] = 1'b0;
      step();
      chk("bin_leds", 32'(leds_o[0]), 7 - exp_pat);
      step();
    end
    chk("bin_ticks", tick_seen[0] - base, 9);
    chk("bin_final", 32'(leds_o[0]), 3'b110);

    // Hold drops frames, including a frame coincident with a one-cycle hold
    repeat (3) begin nf[0] = 1'b1; step(); nf[0] = 1'b0; step(); end
    base = tick_seen[0];
    hd[0] = 1'b1;
    repeat (10) begin nf[0] = 1'b1; step(); nf[0] = 1'b0; step(); end
    hd[0] = 1'b0; step();
    nf[0] = 1'b1; hd[0] = 1'b1; step();
    nf[0] = 1'b0; hd[0] = 1'b0; step();
    chk("hold_no_tick", tick_seen[0] - base, 0);
    nf[0] = 1'b1; step();
    chk("hold_4th_frame_tick", 32'(tick_o[0]), 1);
    nf[0] = 1'b0; step();
    chk("hold_leds", 32'(leds_o[0]), 3'b101);

    // Asynchronous reset mid-count; next tick needs a full 60 frames
    md[1] = 2'b01; md[2] = 2'b01;
    nf[1] = 1'b1; nf[2] = 1'b1;
    repeat (30) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_leds1", 32'(leds_o[1]), 7);
    chk("arst_tick1", 32'(tick_o[1]), 0);
    chk("arst_tick2", 32'(tick_o[2]), 0);
    chk("arst_leds2", 32'(leds_o[2]), 0);
    chk("arst_leds0", 32'(leds_o[0]), 7);
    nf[1] = 1'b0; nf[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    base = tick_seen[1];
    nf[1] = 1'b1;
    repeat (59) step();
    chk("arst_no_early_tick", tick_seen[1] - base, 0);
    step();
    chk("arst_tick_at_60", 32'(tick_o[1]), 1);
    nf[1] = 1'b0;
    step();
    chk("arst_walk_seed", 32'(leds_o[1]), 3'b110);

    // Randomised traffic on all instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 3; d++) begin
        nf[d] = ($urandom_range(0, 9) < 5);
        hd[d] = ($urandom_range(0, 9) < 2);
        if ($urandom_range(0, 15) == 0) md[d] = 2'($urandom_range(0, 3));
        br[d] = PB'($urandom);
      end
      step();
    end
    for (int d = 0; d < 3; d++) begin
      nf[d] = 1'b0; hd[d] = 1'b0; br[d] = '1;
    end
    step();

`ifdef LED_PWM_EN
    // Duty cycle on a lit LED: brightness 4 -> 4/16, 0 -> never, 15 -> always
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    md[2] = 2'b10; nf[2] = 1'b1;
    step();
    nf[2] = 1'b0;
    step();
    br[2] = 4'd4; step();
    lit_cnt = 0;
    repeat (16) begin step(); if (leds_o[2][0]) lit_cnt++; end
    chk("pwm_duty_4", lit_cnt, 4);
    br[2] = 4'd0; step();
    lit_cnt = 0;
    repeat (16) begin step(); if (leds_o[2][0]) lit_cnt++; end
    chk("pwm_duty_0", lit_cnt, 0);
    br[2] = 4'd15; step();
    lit_cnt = 0;
    repeat (16) begin step(); if (leds_o[2][0]) lit_cnt++; end
    chk("pwm_duty_15", lit_cnt, 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
